spec_acq_scheduler: RTL and testbench

Acquisition sequencer for the user-logic signal-processing chain. It sits between the trigger inputs and the FFT / power-spectrum / spectrum-accumulator datapath. Per qualifying trigger it waits a programmable delay, then gates a programmable number of back-to-back FFT frames of dual-sample data (two samples per clock at 200 MHz). It marks the first and last pulse of an accumulation set, and requests readout of the accumulated spectrum once the set completes and the pipeline has drained.

---
 rtl/spec_acq_scheduler.sv | 253 +++++++++++++++++++++++++
 tb/tb_spec_acq_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spec_acq_scheduler.sv
// spec_acq_scheduler
// Acquisition sequencer in front of the FFT / power-spectrum / accumulator
// chain. For each qualifying trigger it waits a programmable delay, then
// gates a programmable number of back-to-back FFT frames. It flags the first
// and last pulse of an accumulation set. When the set is complete and the
// datapath has drained, it requests readout of the accumulated spectrum.
//
// Ports
//   clk_i            system clock
//   rst_i            synchronous active-high reset
//   trigger_vector_i raw trigger lines
//   cfg_arm_i        level enable for triggering
//   cfg_trig_sel_i   trigger line mask
//   cfg_delay_i      clocks from trigger to first frame
//   cfg_frames_i     FFT frames per pulse (0 acts as 1)
//   cfg_pulses_i     pulses per accumulation set (0 acts as 1)
//   rd_ack_i         readout done
//   frame_en_o       sample gate into the FFT
//   frame_start_o    first clock of each frame
//   frame_last_o     last clock of each frame
//   frame_idx_o      frame number within the current pulse
//   acc_first_o      current pulse is first of its set (accumulator overwrites)
//   acc_last_o       current pulse is last of its set
//   pulse_cnt_o      pulses completed in the current set
//   rd_req_o         accumulated spectrum ready
//   trig_miss_o      saturating count of triggers ignored while busy
//   busy_o           high outside IDLE and WAIT_TRIG
module spec_acq_scheduler #(
  parameter int FRAME_CLKS = 512,
  parameter int FLUSH_CLKS = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       trigger_vector_i,
  input  logic             cfg_arm_i,
  input  logic [3:0]       cfg_trig_sel_i,
  input  logic [CNT_W-1:0] cfg_delay_i,
  input  logic [7:0]       cfg_frames_i,
  input  logic [CNT_W-1:0] cfg_pulses_i,
  input  logic             rd_ack_i,
  output logic             frame_en_o,
  output logic             frame_start_o,
  output logic             frame_last_o,
  output logic [7:0]       frame_idx_o,
  output logic             acc_first_o,
  output logic             acc_last_o,
  output logic [CNT_W-1:0] pulse_cnt_o,
  output logic             rd_req_o,
  output logic [CNT_W-1:0] trig_miss_o,
  output logic             busy_o
);

  localparam int FC_W = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam int FL_W = (FLUSH_CLKS > 1) ? $clog2(FLUSH_CLKS) : 1;
  localparam logic [FC_W-1:0] FRAME_END = FC_W'(FRAME_CLKS - 1);
  localparam logic [FL_W-1:0] FLUSH_END = FL_W'(FLUSH_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_DELAY,
    S_FRAME,
    S_FLUSH,
    S_READOUT
  } state_t;

  state_t           state_q, state_d;
  logic             trig_prev_q, trig_prev_d;
  logic [CNT_W-1:0] delay_cnt_q, delay_cnt_d;
  logic [FC_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]       frame_idx_q, frame_idx_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] lat_delay_q, lat_delay_d;
  logic [7:0]       lat_frames_q, lat_frames_d;
  logic [CNT_W-1:0] lat_pulses_q, lat_pulses_d;
  logic [CNT_W-1:0] trig_miss_q, trig_miss_d;
  logic             frame_en_q, frame_en_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_last_q, frame_last_d;
  logic             acc_first_q, acc_first_d;
  logic             acc_last_q, acc_last_d;
  logic             rd_req_q, rd_req_d;
  logic             busy_q, busy_d;

  logic trig_qual;
  logic trig_event;

  // Rising edge of the masked OR of the trigger lines; a held line fires once.
  assign trig_qual  = |(trigger_vector_i & cfg_trig_sel_i);
  assign trig_event = trig_qual & ~trig_prev_q;

  // Next-state logic and the counters that pace delay, frames and flush.
  // The registered outputs are computed from the next-state values, so that
  // each output lines up with the state it describes.
  always_comb begin
    state_d      = state_q;
    trig_prev_d  = trig_qual;
    delay_cnt_d  = delay_cnt_q;
    clk_cnt_d    = clk_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    frame_idx_d  = frame_idx_q;
    pulse_cnt_d  = pulse_cnt_q;
    lat_delay_d  = lat_delay_q;
    lat_frames_d = lat_frames_q;
    lat_pulses_d = lat_pulses_q;
    trig_miss_d  = trig_miss_q;

    case (state_q)
      S_IDLE: begin
        pulse_cnt_d = '0;
        if (cfg_arm_i) begin
          state_d = S_WAIT_TRIG;
        end
      end

      S_WAIT_TRIG: begin
        // Disarm takes priority, and it also abandons a partly finished set.
        if (!cfg_arm_i) begin
          state_d     = S_IDLE;
          pulse_cnt_d = '0;
        end else if (trig_event) begin
          state_d     = S_DELAY;
          delay_cnt_d = '0;
          // The configuration is frozen for the whole set at its first trigger.
          if (pulse_cnt_q == '0) begin
            lat_delay_d  = cfg_delay_i;
            lat_frames_d = (cfg_frames_i == 8'd0) ? 8'd1 : cfg_frames_i;
            lat_pulses_d = (cfg_pulses_i == '0) ? CNT_W'(1) : cfg_pulses_i;
          end
        end
      end

      S_DELAY: begin
        if (delay_cnt_q == lat_delay_q) begin
          state_d     = S_FRAME;
          clk_cnt_d   = '0;
          frame_idx_d = 8'd0;
        end else begin
          delay_cnt_d = delay_cnt_q + CNT_W'(1);
        end
      end

      S_FRAME: begin
        if (clk_cnt_q == FRAME_END) begin
          clk_cnt_d = '0;
          if (frame_idx_q == lat_frames_q - 8'd1) begin
            frame_idx_d = 8'd0;
            pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
            if (pulse_cnt_q + CNT_W'(1) == lat_pulses_q) begin
              state_d     = S_FLUSH;
              flush_cnt_d = '0;
            end else begin
              state_d = S_WAIT_TRIG;
            end
          end else begin
            frame_idx_d = frame_idx_q + 8'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + FC_W'(1);
        end
      end

      S_FLUSH: begin
        if (flush_cnt_q == FLUSH_END) begin
          state_d = S_READOUT;
        end else begin
          flush_cnt_d = flush_cnt_q + FL_W'(1);
        end
      end

      S_READOUT: begin
        if (rd_ack_i) begin
          pulse_cnt_d = '0;
          state_d     = cfg_arm_i ? S_WAIT_TRIG : S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Triggers that arrive while busy are counted and then dropped.
    if (trig_event && (state_q inside {S_DELAY, S_FRAME, S_FLUSH, S_READOUT}) &&
        (trig_miss_q != '1)) begin
      trig_miss_d = trig_miss_q + CNT_W'(1);
    end

    frame_en_d    = (state_d == S_FRAME);
    frame_start_d = frame_en_d && (clk_cnt_d == '0);
    frame_last_d  = frame_en_d && (clk_cnt_d == FRAME_END);
    acc_first_d   = frame_en_d && (pulse_cnt_d == '0);
    acc_last_d    = frame_en_d && (pulse_cnt_d == lat_pulses_d - CNT_W'(1));
    rd_req_d      = (state_d == S_READOUT);
    busy_d        = !(state_d inside {S_IDLE, S_WAIT_TRIG});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      trig_prev_q   <= 1'b0;
      delay_cnt_q   <= '0;
      clk_cnt_q     <= '0;
      flush_cnt_q   <= '0;
      frame_idx_q   <= '0;
      pulse_cnt_q   <= '0;
      lat_delay_q   <= '0;
      lat_frames_q  <= '0;
      lat_pulses_q  <= '0;
      trig_miss_q   <= '0;
      frame_en_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
      acc_first_q   <= 1'b0;
      acc_last_q    <= 1'b0;
      rd_req_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      trig_prev_q   <= trig_prev_d;
      delay_cnt_q   <= delay_cnt_d;
      clk_cnt_q     <= clk_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      frame_idx_q   <= frame_idx_d;
      pulse_cnt_q   <= pulse_cnt_d;
      lat_delay_q   <= lat_delay_d;
      lat_frames_q  <= lat_frames_d;
      lat_pulses_q  <= lat_pulses_d;
      trig_miss_q   <= trig_miss_d;
      frame_en_q    <= frame_en_d;
      frame_start_q <= frame_start_d;
      frame_last_q  <= frame_last_d;
      acc_first_q   <= acc_first_d;
      acc_last_q    <= acc_last_d;
      rd_req_q      <= rd_req_d;
      busy_q        <= busy_d;
    end
  end

  assign frame_en_o    = frame_en_q;
  assign frame_start_o = frame_start_q;
  assign frame_last_o  = frame_last_q;
  assign frame_idx_o   = frame_idx_q;
  assign acc_first_o   = acc_first_q;
  assign acc_last_o    = acc_last_q;
  assign pulse_cnt_o   = pulse_cnt_q;
  assign rd_req_o      = rd_req_q;
  assign trig_miss_o   = trig_miss_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_spec_acq_scheduler.sv
// tb_spec_acq_scheduler
// Directed bench for spec_acq_scheduler. The counters are built narrow
// (CNT_W=8) so that the miss counter reaches saturation after a few hundred
// triggers. The frame and flush lengths keep their default values.
module tb_spec_acq_scheduler;

  localparam int FRAME_CLKS = 512;
  localparam int FLUSH_CLKS = 64;
  localparam int CNT_W      = 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [3:0]       trigger_vector_i;
  logic             cfg_arm_i;
  logic [3:0]       cfg_trig_sel_i;
  logic [CNT_W-1:0] cfg_delay_i;
  logic [7:0]       cfg_frames_i;
  logic [CNT_W-1:0] cfg_pulses_i;
  logic             rd_ack_i;
  logic             frame_en_o;
  logic             frame_start_o;
  logic             frame_last_o;
  logic [7:0]       frame_idx_o;
  logic             acc_first_o;
  logic             acc_last_o;
  logic [CNT_W-1:0] pulse_cnt_o;
  logic             rd_req_o;
  logic [CNT_W-1:0] trig_miss_o;
  logic             busy_o;

  spec_acq_scheduler #(
    .FRAME_CLKS(FRAME_CLKS),
    .FLUSH_CLKS(FLUSH_CLKS),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .trigger_vector_i(trigger_vector_i),
    .cfg_arm_i(cfg_arm_i),
    .cfg_trig_sel_i(cfg_trig_sel_i),
    .cfg_delay_i(cfg_delay_i),
    .cfg_frames_i(cfg_frames_i),
    .cfg_pulses_i(cfg_pulses_i),
    .rd_ack_i(rd_ack_i),
    .frame_en_o(frame_en_o),
    .frame_start_o(frame_start_o),
    .frame_last_o(frame_last_o),
    .frame_idx_o(frame_idx_o),
    .acc_first_o(acc_first_o),
    .acc_last_o(acc_last_o),
    .pulse_cnt_o(pulse_cnt_o),
    .rd_req_o(rd_req_o),
    .trig_miss_o(trig_miss_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checkCount = 0;
  int failCount  = 0;

  int gateLen;
  int gateStarts;
  int gateLasts;
  int gateIdxSig;
  int gateAligned;
  int gateFirst;
  int gateLastFlag;
  int waitN;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Every output packed into one word, used for the all-zero checks.
  function automatic int allOutputs();
    return int'({frame_en_o, frame_start_o, frame_last_o, frame_idx_o, acc_first_o,
                 acc_last_o, pulse_cnt_o, rd_req_o, trig_miss_o, busy_o});
  endfunction

  // Advance one clock, then settle just past the edge before looking at outputs.
  task automatic stepCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic arm, input logic [3:0] sel,
                               input logic [CNT_W-1:0] delay, input logic [7:0] frames,
                               input logic [CNT_W-1:0] pulses);
    cfg_arm_i      = arm;
    cfg_trig_sel_i = sel;
    cfg_delay_i    = delay;
    cfg_frames_i   = frames;
    cfg_pulses_i   = pulses;
  endtask

  // Raise the given lines so the next edge sees the event, then drop them.
  task automatic fireTrigger(input logic [3:0] lines);
    trigger_vector_i = lines;
    stepCycle();
    trigger_vector_i = 4'b0000;
  endtask

  task automatic waitFrameStart(output int n);
    n = 0;
    while (!frame_start_o && n < 100000 / 100) begin
      stepCycle();
      n++;
    end
  endtask

  task automatic waitRdReq(output int n);
    n = 0;
    while (!rd_req_o && n < 1000) begin
      stepCycle();
      n++;
    end
  endtask

  // Walk a whole gate from its first clock, tracking frame boundaries.
  task automatic measureGate();
    gateLen = 0; gateStarts = 0; gateLasts = 0; gateIdxSig = 0;
    gateAligned = 1; gateFirst = 0; gateLastFlag = 0;
    while (frame_en_o && gateLen < 20000) begin
      if (frame_start_o) begin
        gateStarts++;
        gateIdxSig = gateIdxSig * 10 + int'(frame_idx_o);
        if (gateLen % FRAME_CLKS != 0) gateAligned = 0;
      end else if (gateLen % FRAME_CLKS == 0) begin
        gateAligned = 0;
      end
      if (frame_last_o) begin
        gateLasts++;
        if (gateLen % FRAME_CLKS != FRAME_CLKS - 1) gateAligned = 0;
      end else if (gateLen % FRAME_CLKS == FRAME_CLKS - 1) begin
        gateAligned = 0;
      end
      if (acc_first_o) gateFirst = 1;
      if (acc_last_o) gateLastFlag = 1;
      gateLen++;
      stepCycle();
    end
  endtask

  // One accepted trigger followed by its complete gate.
  task automatic runPulse(input logic [3:0] line, input int expDelay, input int expLen,
                          input int expFirst, input int expLast, input int expIdxSig,
                          input string tag);
    int n;
    fireTrigger(line);
    checkOutput({tag, "/accepted_busy"}, int'(busy_o), 1);
    waitFrameStart(n);
    checkOutput({tag, "/start_latency"}, n, expDelay + 1);
    measureGate();
    checkOutput({tag, "/gate_len"}, gateLen, expLen);
    checkOutput({tag, "/frames"}, gateStarts * 100 + gateLasts,
                (expLen / FRAME_CLKS) * 101);
    checkOutput({tag, "/aligned"}, gateAligned, 1);
    checkOutput({tag, "/frame_idx_seq"}, gateIdxSig, expIdxSig);
    checkOutput({tag, "/acc_first"}, gateFirst, expFirst);
    checkOutput({tag, "/acc_last"}, gateLastFlag, expLast);
  endtask

  task automatic doAck();
    rd_ack_i = 1'b1;
    stepCycle();
    rd_ack_i = 1'b0;
  endtask

  task automatic finishSet(input string tag, input int expWait);
    int n;
    waitRdReq(n);
    checkOutput({tag, "/rd_req_latency"}, n, expWait);
    repeat (3) stepCycle();
    checkOutput({tag, "/rd_req_held"}, int'(rd_req_o), 1);
    doAck();
    checkOutput({tag, "/rd_req_dropped"}, int'(rd_req_o), 0);
    checkOutput({tag, "/pulse_cnt_cleared"}, int'(pulse_cnt_o), 0);
    checkOutput({tag, "/not_busy"}, int'(busy_o), 0);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_i = 1'b1;
    trigger_vector_i = 4'b0000;
    rd_ack_i = 1'b0;
    applyStimulus(1'b0, 4'b0000, '0, 8'd0, '0);
    repeat (3) stepCycle();
    checkOutput("reset/outputs", allOutputs(), 0);
    rst_i = 1'b0;
    stepCycle();
    checkOutput("idle/outputs", allOutputs(), 0);

    $display("[TB] single pulse");
    applyStimulus(1'b1, 4'b0001, 8'd0, 8'd1, 8'd1);
    stepCycle();
    checkOutput("single/armed_idle", int'(busy_o), 0);
    runPulse(4'b0001, 0, 512, 1, 1, 0, "single");
    checkOutput("single/pulse_cnt", int'(pulse_cnt_o), 1);
    rd_ack_i = 1'b1;
    repeat (10) stepCycle();
    rd_ack_i = 1'b0;
    checkOutput("single/ack_ignored_in_flush", int'(rd_req_o), 0);
    finishSet("single", 54);

    $display("[TB] masking");
    fireTrigger(4'b0100);
    stepCycle();
    checkOutput("mask/ignored_busy", int'(busy_o), 0);
    checkOutput("mask/no_miss", int'(trig_miss_o), 0);
    applyStimulus(1'b1, 4'b0100, 8'd69, 8'd1, 8'd1);
    runPulse(4'b0100, 69, 512, 1, 1, 0, "mask");
    finishSet("mask", 64);

    $display("[TB] multi frame multi pulse");
    applyStimulus(1'b1, 4'b0001, 8'd5, 8'd3, 8'd4);
    for (int p = 0; p < 4; p++) begin
      runPulse(4'b0001, 5, 1536, (p == 0) ? 1 : 0, (p == 3) ? 1 : 0, 12, "multi");
      checkOutput("multi/pulse_cnt", int'(pulse_cnt_o), p + 1);
      checkOutput("multi/rd_req_only_at_end", int'(rd_req_o), 0);
      checkOutput("multi/busy_between", int'(busy_o), (p == 3) ? 1 : 0);
    end
    finishSet("multi", 64);

    $display("[TB] busy trigger");
    applyStimulus(1'b1, 4'b0001, 8'd0, 8'd1, 8'd2);
    fireTrigger(4'b0001);
    waitFrameStart(n);
    checkOutput("busy/start_latency", n, 1);
    repeat (99) stepCycle();
    fireTrigger(4'b0001);
    checkOutput("busy/miss_in_frame", int'(trig_miss_o), 1);
    checkOutput("busy/gate_still_on", int'(frame_en_o), 1);
    n = 0;
    while (!frame_last_o && n < 1000) begin
      stepCycle();
      n++;
    end
    checkOutput("busy/frame_length_unchanged", n, 411);
    trigger_vector_i = 4'b0001;
    stepCycle();
    trigger_vector_i = 4'b0000;
    checkOutput("busy/miss_on_transition_edge", int'(trig_miss_o), 2);
    checkOutput("busy/back_to_wait", int'(busy_o), 0);
    checkOutput("busy/pulse_cnt", int'(pulse_cnt_o), 1);
    stepCycle();
    runPulse(4'b0001, 0, 512, 0, 1, 0, "busy2");
    finishSet("busy", 64);

    $display("[TB] config latching and disarm");
    applyStimulus(1'b1, 4'b0001, 8'd3, 8'd2, 8'd3);
    runPulse(4'b0001, 3, 1024, 1, 0, 1, "latch0");
    applyStimulus(1'b1, 4'b0001, 8'd50, 8'd5, 8'd1);
    runPulse(4'b0001, 3, 1024, 0, 0, 1, "latch1");
    checkOutput("latch/pulse_cnt", int'(pulse_cnt_o), 2);
    fireTrigger(4'b0001);
    waitFrameStart(n);
    checkOutput("latch2/start_latency", n, 4);
    cfg_arm_i = 1'b0;
    measureGate();
    checkOutput("latch2/gate_len", gateLen, 1024);
    checkOutput("latch2/acc_last", gateLastFlag, 1);
    finishSet("disarm", 64);
    fireTrigger(4'b0001);
    stepCycle();
    checkOutput("disarm/idle_ignores_trigger", int'(busy_o), 0);
    checkOutput("disarm/no_miss_in_idle", int'(trig_miss_o), 2);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 4'b0001, 8'd0, 8'd1, 8'd1);
    stepCycle();
    fireTrigger(4'b0001);
    waitFrameStart(n);
    repeat (200) stepCycle();
    checkOutput("rst/in_frame", int'(frame_en_o), 1);
    rst_i = 1'b1;
    cfg_arm_i = 1'b0;
    stepCycle();
    checkOutput("rst/outputs_zero", allOutputs(), 0);
    rst_i = 1'b0;
    repeat (5) stepCycle();
    fireTrigger(4'b0001);
    stepCycle();
    checkOutput("rst/stays_idle", allOutputs(), 0);

    $display("[TB] zero config");
    applyStimulus(1'b1, 4'b0001, 8'd0, 8'd0, 8'd0);
    stepCycle();
    runPulse(4'b0001, 0, 512, 1, 1, 0, "zero");
    finishSet("zero", 64);

    $display("[TB] miss saturation");
    applyStimulus(1'b1, 4'b0001, 8'd0, 8'd1, 8'd1);
    runPulse(4'b0001, 0, 512, 1, 1, 0, "sat");
    waitRdReq(n);
    checkOutput("sat/rd_req_latency", n, 64);
    repeat (200) begin
      trigger_vector_i = 4'b0001;
      stepCycle();
      trigger_vector_i = 4'b0000;
      stepCycle();
    end
    checkOutput("sat/count_200", int'(trig_miss_o), 200);
    repeat (100) begin
      trigger_vector_i = 4'b0001;
      stepCycle();
      trigger_vector_i = 4'b0000;
      stepCycle();
    end
    checkOutput("sat/saturated", int'(trig_miss_o), 255);
    checkOutput("sat/rd_req_waiting", int'(rd_req_o), 1);
    doAck();
    checkOutput("sat/rd_req_dropped", int'(rd_req_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
